div32_seq: RTL and testbench

Sequential signed 32-bit integer divider for the execute stage. It computes the quotient of `data_operandA / data_operandB` using one restoring-division step per clock, so the ALU datapath avoids a 32-level combinational divider. The pipeline stalls while the divider is busy and resumes on a one-cycle ready pulse. Exceptions (divide-by-zero and signed overflow) are reported alongside the result.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 26 ++
 rtl/div32_seq.sv | 128 ++++++++++++
 tb/tb_div32_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the sequential signed divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   // FSM encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference if it is non-negative.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem,
   input  logic             din,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             qbit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // The extra top bit keeps the trial subtract exact even for |B| = 2^31.
   always_comb begin
      shifted  = {rem, din};
      diff     = shifted - {2'b00, divisor};
      qbit     = ~diff[WIDTH+1];
      rem_next = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/div32_seq.sv
// Sequential signed divider: one restoring step per clock, quotient truncated
// toward zero, divide-by-zero and INT_MIN/-1 reported as exceptions.
//
// state | meaning
// IDLE  | waiting for ctrl_DIV
// RUN   | performing the 32 restoring steps
// DONE  | registering the result and pulsing data_resultRDY
module div32_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [5:0]       LAST_STEP = 6'(WIDTH - 1);

   logic [1:0]       state;
   logic [5:0]       step_cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] dq;
   logic [WIDTH-1:0] divisor;
   logic             q_neg;
   logic             exc_pend;
   logic [WIDTH-1:0] exc_val;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             start_zero;
   logic             start_ovf;
   logic             start_exc;
   logic [WIDTH:0]   rem_next;
   logic             qbit;
   logic [WIDTH-1:0] q_final;

   // Operand magnitudes, exception detection and final sign correction.
   always_comb begin
      abs_a      = data_operandA[WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
      abs_b      = data_operandB[WIDTH-1] ? (~data_operandB + ONE) : data_operandB;
      start_zero = (data_operandB == '0);
      start_ovf  = (data_operandA == INT_MIN) && (data_operandB == '1);
      start_exc  = start_zero || start_ovf;
      if (exc_pend) begin
         q_final = exc_val;
      end else if (q_neg) begin
         q_final = ~dq + ONE;
      end else begin
         q_final = dq;
      end
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .din      (dq[WIDTH-1]),
      .divisor  (divisor),
      .rem_next (rem_next),
      .qbit     (qbit)
   );

   // FSM, step counter, dividend/quotient shift register and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         step_cnt       <= '0;
         rem            <= '0;
         dq             <= '0;
         divisor        <= '0;
         q_neg          <= 1'b0;
         exc_pend       <= 1'b0;
         exc_val        <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;

         // The finishing result is delivered even if a new start arrives now.
         if (state == DONE) begin
            data_result    <= q_final;
            data_exception <= exc_pend;
            data_resultRDY <= 1'b1;
         end

         if (ctrl_DIV) begin
            dq       <= abs_a;
            divisor  <= abs_b;
            q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rem      <= '0;
            step_cnt <= '0;
            exc_pend <= start_exc;
            exc_val  <= start_zero ? '0 : INT_MIN;
            state    <= start_exc ? DONE : RUN;
            busy     <= ~start_exc;
         end else begin
            case (state)
               IDLE: ;
               RUN: begin
                  rem      <= rem_next;
                  dq       <= {dq[WIDTH-2:0], qbit};
                  step_cnt <= step_cnt + 6'd1;
                  if (step_cnt == LAST_STEP) begin
                     state <= DONE;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Directed and random checks for the sequential signed divider.
module tb_div32_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   div32_seq #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands with ctrl_DIV for one rising edge, then scramble them.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_DIV      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Called right after the start edge; waits (bounded) for RDY and checks it.
   task automatic wait_check(input string tag, input logic [31:0] exp_q, input logic exp_exc,
                             input int exp_lat, input bit full);
      int          lat;
      int          busy_cnt;
      logic [31:0] held;
      logic        unstable;
      logic        busy_at_rdy;
      lat         = 0;
      busy_cnt    = 0;
      held        = '0;
      unstable    = 1'b0;
      busy_at_rdy = 1'b1;
      for (int i = 0; i <= 40; i++) begin
         @(negedge clock);
         if (i == 0) begin
            held = data_result;
         end else if (data_resultRDY === 1'b1) begin
            lat         = i;
            busy_at_rdy = busy;
            break;
         end else if (data_result !== held) begin
            unstable = 1'b1;
         end
         if (busy === 1'b1) busy_cnt++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, data_result, exp_q);
      check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
      if (full) begin
         check({tag, " busy cycles"}, 32'(busy_cnt), (exp_lat == 1) ? 32'd0 : 32'd33);
         check({tag, " busy at rdy"}, {31'd0, busy_at_rdy}, 32'd0);
         check({tag, " result held"}, {31'd0, unstable}, 32'd0);
         @(negedge clock);
         check({tag, " rdy width"}, {31'd0, data_resultRDY}, 32'd0);
      end
   endtask

   logic [31:0] ra, rb, rexp;
   logic        rexc;
   int          rlat;
   int          sa, sb;
   logic        rdy_seen;

   initial begin
      reset         = 1'b1;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("reset result", data_result, 32'd0);
      check("reset exception", {31'd0, data_exception}, 32'd0);
      check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);

      start_op(32'd100, 32'd7);
      wait_check("100/7", 32'd14, 1'b0, 33, 1'b1);
      start_op(32'hFFFF_FF9C, 32'd7);
      wait_check("-100/7", 32'hFFFF_FFF2, 1'b0, 33, 1'b1);
      start_op(32'd100, 32'hFFFF_FFF9);
      wait_check("100/-7", 32'hFFFF_FFF2, 1'b0, 33, 1'b1);
      start_op(32'hFFFF_FF9C, 32'hFFFF_FFF9);
      wait_check("-100/-7", 32'd14, 1'b0, 33, 1'b1);

      start_op(32'd5, 32'd0);
      wait_check("div by zero", 32'd0, 1'b1, 1, 1'b1);
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_check("overflow", 32'h8000_0000, 1'b1, 1, 1'b1);

      start_op(32'd0, 32'd7);
      wait_check("0/7", 32'd0, 1'b0, 33, 1'b1);
      start_op(32'hFFFF_FFF9, 32'd2);
      wait_check("-7/2", 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
      start_op(32'h8000_0000, 32'h8000_0000);
      wait_check("min/min", 32'd1, 1'b0, 33, 1'b1);
      start_op(32'd5, 32'h8000_0000);
      wait_check("5/min", 32'd0, 1'b0, 33, 1'b1);
      start_op(32'h7FFF_FFFF, 32'd1);
      wait_check("max/1", 32'h7FFF_FFFF, 1'b0, 33, 1'b1);
      start_op(32'h8000_0000, 32'd2);
      wait_check("min/2", 32'hC000_0000, 1'b0, 33, 1'b1);
      start_op(32'h8000_0000, 32'd1);
      wait_check("min/1", 32'h8000_0000, 1'b0, 33, 1'b1);

      // Abort in RUN: second pulse ten cycles after the first.
      start_op(32'd1000, 32'd10);
      rdy_seen = 1'b0;
      repeat (9) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) rdy_seen = 1'b1;
      end
      start_op(32'd9, 32'd3);
      check("abort no early rdy", {31'd0, rdy_seen}, 32'd0);
      wait_check("abort restart", 32'd3, 1'b0, 33, 1'b1);

      // New start while in DONE: old RDY still pulses, new op runs normally.
      start_op(32'd20, 32'd4);
      repeat (32) @(negedge clock);
      start_op(32'd7, 32'd2);
      check("b2b first rdy", {31'd0, data_resultRDY}, 32'd1);
      check("b2b first result", data_result, 32'd5);
      check("b2b first exception", {31'd0, data_exception}, 32'd0);
      wait_check("b2b second", 32'd3, 1'b0, 33, 1'b1);

      // Reset in the middle of an operation.
      start_op(32'd1000, 32'd10);
      repeat (20) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("midreset result", data_result, 32'd0);
      check("midreset exception", {31'd0, data_exception}, 32'd0);
      check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
      check("midreset busy", {31'd0, busy}, 32'd0);
      rdy_seen = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) rdy_seen = 1'b1;
      end
      check("midreset no rdy", {31'd0, rdy_seen}, 32'd0);

      for (int n = 0; n < 200; n++) begin
         ra = $urandom;
         rb = $urandom;
         if (n % 4 == 0) rb = 32'($urandom_range(1, 100));
         if (n % 8 == 1) rb = -32'($urandom_range(1, 100));
         if (n == 7) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         if (rb == 32'd0) rb = 32'd1;
         sa = ra;
         sb = rb;
         if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) begin
            rexp = 32'h8000_0000;
            rexc = 1'b1;
            rlat = 1;
         end else begin
            rexp = 32'(sa / sb);
            rexc = 1'b0;
            rlat = 33;
         end
         start_op(ra, rb);
         wait_check("random", rexp, rexc, rlat, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
